// File: rtl/mb_scan_addr_gen.sv
// Macroblock-order pixel address generator for the frame-buffer read path.
// Emits one (x, y, addr) beat per SUB-wide pixel group, in row order or SUBxSUB block order.
module mb_scan_addr_gen #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 288,
    parameter int MB     = 16,
    parameter int SUB    = 4,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT),
    parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic          addr_ready,
    output logic          addr_valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          mb_first,
    output logic          mb_last,
    output logic          frame_last,
    output logic          busy,
    output logic          done
);
    localparam int NG  = MB / SUB;
    localparam int NMX = WIDTH / MB;
    localparam int NMY = HEIGHT / MB;
    localparam int CW  = $clog2(MB) + 1;
    localparam int MXW = $clog2(NMX) + 1;
    localparam int MYW = $clog2(NMY) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         state;
    logic           mode_q;
    logic [CW-1:0]  ca, cb, cc;
    logic [MXW-1:0] mbx;
    logic [MYW-1:0] mby;

    logic           m, load;
    logic [CW-1:0]  amax, bmax, cmax, na, nb, nc;
    logic [MXW-1:0] nmx;
    logic [MYW-1:0] nmy;
    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;
    logic [AW-1:0]  naddr;
    logic           nfirst, nlast, nflast;
    int             ix, iy;

    // Counter roles: mode 0 -> a=group, b=row, c unused; mode 1 -> a=row in block, b=block col, c=block row.
    always_comb begin
        m    = (state == IDLE) ? mode : mode_q;
        amax = m ? CW'(SUB-1) : CW'(NG-1);
        bmax = m ? CW'(NG-1)  : CW'(MB-1);
        cmax = m ? CW'(NG-1)  : '0;
        na   = ca;
        nb   = cb;
        nc   = cc;
        nmx  = mbx;
        nmy  = mby;
        if (state == IDLE) begin
            na  = '0;
            nb  = '0;
            nc  = '0;
            nmx = '0;
            nmy = '0;
        end else if (ca != amax) begin
            na = ca + 1'b1;
        end else begin
            na = '0;
            if (cb != bmax) begin
                nb = cb + 1'b1;
            end else begin
                nb = '0;
                if (cc != cmax) begin
                    nc = cc + 1'b1;
                end else begin
                    nc = '0;
                    if (mbx != MXW'(NMX-1)) begin
                        nmx = mbx + 1'b1;
                    end else begin
                        nmx = '0;
                        nmy = mby + 1'b1;
                    end
                end
            end
        end

        if (m) begin
            ix = int'(nmx)*MB + int'(nb)*SUB;
            iy = int'(nmy)*MB + int'(nc)*SUB + int'(na);
        end else begin
            ix = int'(nmx)*MB + int'(na)*SUB;
            iy = int'(nmy)*MB + int'(nb);
        end
        nx     = XW'(ix);
        ny     = YW'(iy);
        naddr  = AW'(ny) * AW'(WIDTH) + AW'(nx);
        nfirst = (na == '0) && (nb == '0) && (nc == '0);
        nlast  = (na == amax) && (nb == bmax) && (nc == cmax);
        nflast = nlast && (nmx == MXW'(NMX-1)) && (nmy == MYW'(NMY-1));
        load   = ((state == IDLE) && start) ||
                 ((state == SCAN) && addr_valid && addr_ready && !frame_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            ca         <= '0;
            cb         <= '0;
            cc         <= '0;
            mbx        <= '0;
            mby        <= '0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            mb_first   <= 1'b0;
            mb_last    <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= SCAN;
                        mode_q     <= mode;
                        addr_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (addr_valid && addr_ready && frame_last) begin
                        state      <= DONE;
                        addr_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        mb_first   <= 1'b0;
                        mb_last    <= 1'b0;
                        frame_last <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Position and outputs move together so a stalled beat never tears.
            if (load) begin
                ca         <= na;
                cb         <= nb;
                cc         <= nc;
                mbx        <= nmx;
                mby        <= nmy;
                x          <= nx;
                y          <= ny;
                addr       <= naddr;
                mb_first   <= nfirst;
                mb_last    <= nlast;
                frame_last <= nflast;
            end
        end
    end
endmodule

// File: tb/tb_mb_scan_addr_gen.sv
module tb_mb_scan_addr_gen;
  localparam int SW = 32, SH = 32;
  localparam int SXW = $clog2(SW), SYW = $clog2(SH), SAW = $clog2(SW*SH);
  localparam int DW = 352, DH = 288;
  localparam int DXW = $clog2(DW), DYW = $clog2(DH), DAW = $clog2(DW*DH);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic start_s = 0, mode_s = 0, ready_s = 0;
  logic addr_valid_s, mb_first_s, mb_last_s, frame_last_s, busy_s, done_s;
  logic [SXW-1:0] x_s;
  logic [SYW-1:0] y_s;
  logic [SAW-1:0] addr_s;

  logic start_d = 0, mode_d = 0, ready_d = 0;
  logic addr_valid_d, mb_first_d, mb_last_d, frame_last_d, busy_d, done_d;
  logic [DXW-1:0] x_d;
  logic [DYW-1:0] y_d;
  logic [DAW-1:0] addr_d;

  mb_scan_addr_gen #(.WIDTH(SW), .HEIGHT(SH)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .addr_ready(ready_s),
    .addr_valid(addr_valid_s), .x(x_s), .y(y_s), .addr(addr_s),
    .mb_first(mb_first_s), .mb_last(mb_last_s), .frame_last(frame_last_s),
    .busy(busy_s), .done(done_s));

  mb_scan_addr_gen dut_d (
    .clk(clk), .reset(reset), .start(start_d), .mode(mode_d), .addr_ready(ready_d),
    .addr_valid(addr_valid_d), .x(x_d), .y(y_d), .addr(addr_d),
    .mb_first(mb_first_d), .mb_last(mb_last_d), .frame_last(frame_last_d),
    .busy(busy_d), .done(done_d));

  logic [22:0] tuple_s;
  assign tuple_s = {x_s, y_s, addr_s, mb_first_s, mb_last_s, frame_last_s};

  int total = 0, bad = 0;
  int ex[$], ey[$];
  int aq_x[$], aq_y[$], aq_a[$];
  logic [2:0] aq_f[$];
  int n_unstable, n_done, done_gap;
  bit timed_out;
  logic [11:0] snap0;

  task automatic build_model(input int w, input int h, input bit m);
    ex.delete();
    ey.delete();
    for (int my = 0; my < h/16; my++)
      for (int mx = 0; mx < w/16; mx++)
        if (!m) begin
          for (int r = 0; r < 16; r++)
            for (int g = 0; g < 4; g++) begin
              ex.push_back(mx*16 + g*4);
              ey.push_back(my*16 + r);
            end
        end else begin
          for (int by = 0; by < 4; by++)
            for (int bx = 0; bx < 4; bx++)
              for (int r = 0; r < 4; r++) begin
                ex.push_back(mx*16 + bx*4);
                ey.push_back(my*16 + by*4 + r);
              end
        end
  endtask

  task automatic run_s(input bit m, input bit rnd);
    logic [22:0] prev;
    bit stalled, seen_last;
    int gap;
    aq_x.delete(); aq_y.delete(); aq_a.delete(); aq_f.delete();
    n_unstable = 0; n_done = 0; done_gap = -1; timed_out = 1;
    stalled = 0; seen_last = 0; gap = 0; prev = '0;
    mode_s = m;
    start_s = 1;
    @(negedge clk);
    start_s = 0;
    snap0 = {addr_valid_s, x_s, y_s, mb_first_s};
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (seen_last) gap++;
      if (done_s) begin
        n_done++;
        if (done_gap < 0) done_gap = gap;
      end
      if (seen_last && gap >= 4) begin
        timed_out = 0;
        break;
      end
      if (stalled && tuple_s !== prev) n_unstable++;
      ready_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (addr_valid_s && ready_s) begin
        aq_x.push_back(int'(x_s));
        aq_y.push_back(int'(y_s));
        aq_a.push_back(int'(addr_s));
        aq_f.push_back({mb_first_s, mb_last_s, frame_last_s});
        if (frame_last_s) seen_last = 1;
      end
      stalled = addr_valid_s && !ready_s;
      prev = tuple_s;
      @(negedge clk);
    end
    ready_s = 1;
    while (aq_x.size() < 300) begin
      aq_x.push_back(-1); aq_y.push_back(-1); aq_a.push_back(-1); aq_f.push_back(3'b111);
    end
  endtask

  task automatic check_seq(input string name);
    int errs, fi;
    logic [2:0] ef;
    errs = 0; fi = -1;
    for (int i = 0; i < 256; i++) begin
      ef = {(i % 64) == 0, (i % 64) == 63, i == 255};
      if (aq_x[i] !== ex[i] || aq_y[i] !== ey[i] || aq_a[i] !== ey[i]*SW + ex[i] || aq_f[i] !== ef) begin
        errs++;
        if (fi < 0) fi = i;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s: %0d bad beats, first #%0d got (%0d,%0d) a=%0d f=%b want (%0d,%0d) a=%0d",
               name, errs, fi, aq_x[fi], aq_y[fi], aq_a[fi], aq_f[fi], ex[fi], ey[fi], ey[fi]*SW + ex[fi]);
    end
  endtask

  task automatic test_reset;
    reset = 1; start_s = 1; start_d = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({addr_valid_s, busy_s, done_s, mb_first_s, mb_last_s, frame_last_s, x_s, y_s, addr_s} !== '0) begin
      bad++;
      $display("FAIL reset_s: got v=%b b=%b d=%b x=%0d y=%0d a=%0d want all 0",
               addr_valid_s, busy_s, done_s, x_s, y_s, addr_s);
    end
    total++;
    if ({addr_valid_d, busy_d, done_d, mb_first_d, mb_last_d, frame_last_d, x_d, y_d, addr_d} !== '0) begin
      bad++;
      $display("FAIL reset_d: got v=%b b=%b d=%b x=%0d y=%0d a=%0d want all 0",
               addr_valid_d, busy_d, done_d, x_d, y_d, addr_d);
    end
    reset = 0; start_s = 0; start_d = 0;
    @(negedge clk);
    total++;
    if (addr_valid_s !== 1'b0 || busy_s !== 1'b0) begin
      bad++;
      $display("FAIL reset_start: got v=%b busy=%b want 0 0", addr_valid_s, busy_s);
    end
  endtask

  task automatic test_mode0;
    build_model(SW, SH, 0);
    run_s(0, 0);
    total++;
    if (timed_out) begin bad++; $display("FAIL m0_timeout: frame did not end within budget"); end
    total++;
    if (snap0 !== {1'b1, 5'd0, 5'd0, 1'b1}) begin
      bad++;
      $display("FAIL m0_latency: got %b want %b", snap0, {1'b1, 5'd0, 5'd0, 1'b1});
    end
    check_seq("m0_seq");
    total++;
    if (aq_x[4] !== 0 || aq_y[4] !== 1) begin
      bad++;
      $display("FAIL m0_beat4: got (%0d,%0d) want (0,1)", aq_x[4], aq_y[4]);
    end
    total++;
    if (aq_x[63] !== 12 || aq_y[63] !== 15 || aq_f[63] !== 3'b010) begin
      bad++;
      $display("FAIL m0_mblast: got (%0d,%0d) f=%b want (12,15) f=010", aq_x[63], aq_y[63], aq_f[63]);
    end
    total++;
    if (aq_x[64] !== 16 || aq_y[64] !== 0 || aq_a[64] !== 16 || aq_f[64] !== 3'b100) begin
      bad++;
      $display("FAIL m0_mb2: got (%0d,%0d) a=%0d f=%b want (16,0) a=16 f=100", aq_x[64], aq_y[64], aq_a[64], aq_f[64]);
    end
    total++;
    if (aq_x[255] !== 28 || aq_y[255] !== 31 || aq_a[255] !== 1020 || aq_f[255] !== 3'b011) begin
      bad++;
      $display("FAIL m0_end: got (%0d,%0d) a=%0d f=%b want (28,31) a=1020 f=011", aq_x[255], aq_y[255], aq_a[255], aq_f[255]);
    end
    total++;
    if (aq_x[256] !== -1) begin
      bad++;
      $display("FAIL m0_count: extra beat (%0d,%0d) want 256 beats", aq_x[256], aq_y[256]);
    end
    total++;
    if (done_gap !== 1 || n_done !== 1) begin
      bad++;
      $display("FAIL m0_done: got gap=%0d count=%0d want 1 1", done_gap, n_done);
    end
  endtask

  task automatic test_mode1;
    build_model(SW, SH, 1);
    run_s(1, 0);
    total++;
    if (timed_out) begin bad++; $display("FAIL m1_timeout: frame did not end within budget"); end
    check_seq("m1_seq");
    total++;
    if (aq_x[1] !== 0 || aq_y[1] !== 1 || aq_x[4] !== 4 || aq_y[4] !== 0) begin
      bad++;
      $display("FAIL m1_start: got (%0d,%0d),(%0d,%0d) want (0,1),(4,0)", aq_x[1], aq_y[1], aq_x[4], aq_y[4]);
    end
    total++;
    if (aq_x[16] !== 0 || aq_y[16] !== 4) begin
      bad++;
      $display("FAIL m1_blkrow: got (%0d,%0d) want (0,4)", aq_x[16], aq_y[16]);
    end
    total++;
    if (aq_x[63] !== 12 || aq_y[63] !== 15 || aq_f[63] !== 3'b010) begin
      bad++;
      $display("FAIL m1_mblast: got (%0d,%0d) f=%b want (12,15) f=010", aq_x[63], aq_y[63], aq_f[63]);
    end
    total++;
    if (aq_x[128] !== 0 || aq_y[128] !== 16 || aq_a[128] !== 512 || aq_f[128] !== 3'b100) begin
      bad++;
      $display("FAIL m1_mb3: got (%0d,%0d) a=%0d f=%b want (0,16) a=512 f=100", aq_x[128], aq_y[128], aq_a[128], aq_f[128]);
    end
    total++;
    if (done_gap !== 1 || n_done !== 1) begin
      bad++;
      $display("FAIL m1_done: got gap=%0d count=%0d want 1 1", done_gap, n_done);
    end
  endtask

  task automatic test_random_ready;
    build_model(SW, SH, 0);
    run_s(0, 1);
    total++;
    if (timed_out) begin bad++; $display("FAIL rnd_timeout: frame did not end within budget"); end
    check_seq("rnd_seq");
    total++;
    if (aq_x[256] !== -1) begin
      bad++;
      $display("FAIL rnd_count: extra beat (%0d,%0d) want 256 beats", aq_x[256], aq_y[256]);
    end
    total++;
    if (n_unstable !== 0) begin
      bad++;
      $display("FAIL rnd_stall: got %0d unstable stalled cycles want 0", n_unstable);
    end
    total++;
    if (n_done !== 1) begin
      bad++;
      $display("FAIL rnd_done: got %0d done pulses want 1", n_done);
    end
  endtask

  task automatic test_back_to_back;
    int beats, k;
    mode_s = 0; ready_s = 1; start_s = 1;
    @(negedge clk);
    total++;
    if (!(addr_valid_s === 1 && x_s === 0 && y_s === 0 && mb_first_s === 1)) begin
      bad++;
      $display("FAIL b2b_first: got v=%b (%0d,%0d) first=%b want 1 (0,0) 1", addr_valid_s, x_s, y_s, mb_first_s);
    end
    for (int f = 0; f < 2; f++) begin
      beats = 0;
      for (k = 0; k < 1000 && !done_s; k++) begin
        if (addr_valid_s && ready_s) beats++;
        @(negedge clk);
      end
      total++;
      if (done_s !== 1'b1 || beats !== 256) begin
        bad++;
        $display("FAIL b2b_frame%0d: got done=%b beats=%0d want 1 256", f, done_s, beats);
      end
      @(negedge clk);
      total++;
      if (addr_valid_s !== 1'b0 || done_s !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle%0d: got v=%b done=%b want 0 0", f, addr_valid_s, done_s);
      end
      @(negedge clk);
      total++;
      if (!(addr_valid_s === 1 && x_s === 0 && y_s === 0 && mb_first_s === 1)) begin
        bad++;
        $display("FAIL b2b_restart%0d: got v=%b (%0d,%0d) first=%b want 1 (0,0) 1", f, addr_valid_s, x_s, y_s, mb_first_s);
      end
    end
    start_s = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int beats, nd;
    mode_d = 0; ready_d = 1; start_d = 1;
    @(negedge clk);
    start_d = 0;
    beats = 0;
    for (int k = 0; k < 500 && beats < 100; k++) begin
      if (addr_valid_d && ready_d) beats++;
      @(negedge clk);
    end
    total++;
    if (beats !== 100) begin
      bad++;
      $display("FAIL rst_mid_beats: got %0d want 100", beats);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    total++;
    if ({addr_valid_d, busy_d, done_d} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_abort: got v=%b busy=%b done=%b want 0 0 0", addr_valid_d, busy_d, done_d);
    end
    nd = 0;
    repeat (4) begin
      if (done_d || addr_valid_d) nd++;
      @(negedge clk);
    end
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL rst_mid_quiet: got %0d cycles with done/valid want 0", nd);
    end
    start_d = 1;
    @(negedge clk);
    start_d = 0;
    total++;
    if (!(addr_valid_d === 1 && x_d === 0 && y_d === 0 && addr_d === 0 && mb_first_d === 1)) begin
      bad++;
      $display("FAIL rst_mid_restart: got v=%b (%0d,%0d) a=%0d first=%b want 1 (0,0) 0 1",
               addr_valid_d, x_d, y_d, addr_d, mb_first_d);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int beats, errs, lx, ly, la, nd;
    build_model(DW, DH, 0);
    beats = 0; errs = 0; lx = -1; ly = -1; la = -1; nd = 0;
    mode_d = 0; ready_d = 1; start_d = 1;
    @(negedge clk);
    start_d = 0;
    for (int k = 0; k < 30000; k++) begin
      if (done_d) begin
        nd++;
        break;
      end
      start_d = (beats == 500) || (beats >= 3000 && beats < 3005);
      if (beats == 1000) mode_d = 1;
      if (addr_valid_d && ready_d) begin
        if (beats >= ex.size()) errs++;
        else if (int'(x_d) !== ex[beats] || int'(y_d) !== ey[beats] || int'(addr_d) !== ey[beats]*DW + ex[beats]) errs++;
        if (frame_last_d) begin
          lx = int'(x_d); ly = int'(y_d); la = int'(addr_d);
        end
        beats++;
      end
      @(negedge clk);
    end
    start_d = 0; mode_d = 0;
    total++;
    if (nd !== 1) begin bad++; $display("FAIL full_done: got %0d want 1", nd); end
    total++;
    if (beats !== 25344) begin bad++; $display("FAIL full_count: got %0d want 25344", beats); end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL full_seq: got %0d mismatched beats want 0", errs); end
    total++;
    if (lx !== 348 || ly !== 287 || la !== 101372) begin
      bad++;
      $display("FAIL full_end: got (%0d,%0d) a=%0d want (348,287) a=101372", lx, ly, la);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mode0();
    test_mode1();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
